// File: rtl/seq_detector_mealy_prog.sv
// Run-time programmable Mealy serial pattern detector with valid qualifier,
// saturating match counter and illegal-length flag.
module seq_detector_mealy_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(4'b1101),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               din_valid,
  input  logic               din,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               cfg_err_q, cfg_err_d;
  logic [MAX_LEN-2:0] history_q, history_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [MAX_LEN-1:0] window;
  logic [LEN_W-1:0]   len_m1;
  logic               win_eq;
  logic               fill_ok;
  logic               cfg_legal;
  logic               match;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_fill(input logic [LEN_W-1:0] v,
                                                    input logic [LEN_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  // The newest bit (din) sits at window[0]; only the low len bits take part.
  assign window    = {history_q, din};
  assign len_m1    = len_q - 1'b1;
  assign fill_ok   = (fill_q >= len_m1);
  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);

  always_comb begin
    win_eq = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(len_q)) && (window[i] != pattern_q[i])) win_eq = 1'b0;
    end
  end

  assign match = din_valid & ~reset & ~cfg_load & ~cfg_err_q & fill_ok & win_eq;

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    cfg_err_d = cfg_err_q;
    history_d = history_q;
    fill_d    = fill_q;
    count_d   = count_q;

    if (cfg_load) begin
      // An illegal length keeps the old config but still restarts the history.
      history_d = '0;
      fill_d    = '0;
      if (cfg_legal) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (din_valid) begin
      if (match && !overlap_q) begin
        history_d = '0;
        fill_d    = '0;
      end else begin
        history_d = window[MAX_LEN-2:0];
        fill_d    = sat_inc_fill(fill_q, len_m1);
      end
    end

    if (cnt_clr)    count_d = '0;
    else if (match) count_d = sat_inc_cnt(count_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= DEF_LEN_L;
      overlap_q <= DEF_OVERLAP;
      cfg_err_q <= 1'b0;
      history_q <= '0;
      fill_q    <= '0;
      count_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      cfg_err_q <= cfg_err_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
    end
  end

  assign dout        = match;
  assign match_count = count_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_mealy_prog.sv
// Bench for seq_detector_mealy_prog: directed vector table followed by
// randomized traffic checked against a queue-based reference model.
module tb_seq_detector_mealy_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;
  logic               dout;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  seq_detector_mealy_prog #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
    .DEF_PATTERN(8'b0000_1101), .DEF_LEN(4), .DEF_OVERLAP(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .din_valid(din_valid), .din(din), .dout(dout),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       clr;
    logic       vld;
    logic       d;
    logic       xd;
    logic       xe;
    int         xc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic ld, input logic [7:0] pat,
                     input logic [3:0] len, input logic ovl, input logic clr,
                     input logic vld, input logic d, input logic xd,
                     input logic xe, input int xc);
    vec_t v;
    v.rst = rst; v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl;
    v.clr = clr; v.vld = vld; v.d = d; v.xd = xd; v.xe = xe; v.xc = xc;
    vecs.push_back(v);
  endtask

  // bits[n-1] is presented first; mask marks the bits that must raise dout.
  task automatic add_bits(input int n, input logic [15:0] bits,
                          input logic [15:0] mask, input logic xe);
    for (int i = n - 1; i >= 0; i--)
      add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, bits[i], mask[i], xe, -1);
  endtask

  task automatic idle(input int xc);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, xc);
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [7:0] pat,
                       input logic [3:0] len, input logic ovl, input logic clr,
                       input logic vld, input logic d);
    reset = rst; cfg_load = ld; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; cnt_clr = clr; din_valid = vld; din = d;
  endtask

  // Reference model: the valid bits seen since the last clear, in arrival order.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_err;
  int         m_cnt;

  task automatic m_reset();
    mq.delete();
    m_pat = 8'h0D; m_len = 4; m_ovl = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  function automatic bit m_dout(input bit rst, input bit ld, input bit vld, input bit d);
    int base;
    if (rst || ld || !vld || m_err) return 1'b0;
    if (mq.size() < m_len - 1) return 1'b0;
    base = mq.size() - (m_len - 1);
    for (int k = 0; k < m_len - 1; k++)
      if (mq[base + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return d == m_pat[0];
  endfunction

  task automatic m_step(input bit rst, input bit ld, input logic [7:0] pat,
                        input int len, input bit ovl, input bit clr,
                        input bit vld, input bit d);
    bit hit;
    hit = m_dout(rst, ld, vld, d);
    if (rst) begin
      m_reset();
      return;
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    if (ld) begin
      mq.delete();
      if (len >= 1 && len <= MAX_LEN) begin
        m_pat = pat; m_len = len; m_ovl = ovl; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (vld) begin
      if (hit && !m_ovl) mq.delete();
      else begin
        mq.push_back(d);
        if (mq.size() > MAX_LEN - 1) void'(mq.pop_front());
      end
    end
  endtask

  initial begin
    // Reset: dout held low even with a valid 1 on the line.
    add(1, 0, 8'h00, 4'd0, 0, 0, 1, 1, 0, 0, -1);
    add(1, 0, 8'h00, 4'd0, 0, 0, 1, 1, 0, 0, 0);
    // Defaults: 1101 non-overlapping.
    add_bits(10, 16'b11_0110_1101, 16'b00_0100_0001, 1'b0);
    idle(2);
    // 1101 overlapping, count cleared with the load.
    add(0, 1, 8'h0D, 4'd4, 1, 1, 1, 1, 0, 0, 2);
    add_bits(10, 16'b11_0110_1101, 16'b00_0100_1001, 1'b0);
    idle(3);
    // 8-bit A5 with a 3-cycle valid gap after bit 3.
    add(0, 1, 8'hA5, 4'd8, 0, 1, 1, 0, 0, 0, 3);
    add_bits(3, 16'b101, 16'b000, 1'b0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 0, -1);
    add_bits(5, 16'b00101, 16'b00001, 1'b0);
    idle(1);
    // Illegal lengths 0 and 9, then a legal 3-bit load with junk upper bits.
    add(0, 1, 8'h0F, 4'd0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 1, 8'h05, 4'd9, 1, 0, 1, 1, 0, 1, 1);
    add_bits(4, 16'b1101, 16'b0000, 1'b1);
    add(0, 1, 8'hFD, 4'd3, 0, 0, 1, 1, 0, 1, 1);
    add_bits(3, 16'b101, 16'b001, 1'b0);
    idle(2);
    // len=1 pattern 1: counter saturation, then clear beats increment.
    add(0, 1, 8'h01, 4'd1, 0, 1, 1, 1, 0, 0, 2);
    add_bits(1, 16'b0, 16'b0, 1'b0);
    for (int i = 0; i < 254; i++) add_bits(1, 16'b1, 16'b1, 1'b0);
    idle(254);
    for (int i = 0; i < 46; i++) add_bits(1, 16'b1, 16'b1, 1'b0);
    idle(255);
    add(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 0, 255);
    idle(0);
    // Reset mid-sequence never completes a partial pattern.
    add(1, 0, 8'h00, 4'd0, 0, 0, 1, 1, 0, 0, 0);
    add_bits(3, 16'b110, 16'b000, 1'b0);
    add(1, 0, 8'h00, 4'd0, 0, 0, 1, 1, 0, 0, 0);
    add_bits(1, 16'b1, 16'b0, 1'b0);
    add_bits(4, 16'b1101, 16'b0001, 1'b0);
    idle(1);
    // Load on the would-be matching bit suppresses dout and flushes history.
    add_bits(3, 16'b110, 16'b000, 1'b0);
    add(0, 1, 8'h0D, 4'd4, 0, 0, 1, 1, 0, 0, 1);
    add_bits(4, 16'b1101, 16'b0001, 1'b0);
    idle(2);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ld, vecs[i].pat, vecs[i].len, vecs[i].ovl,
            vecs[i].clr, vecs[i].vld, vecs[i].d);
      #1;
      chk($sformatf("vec%0d_dout", i), int'(dout), int'(vecs[i].xd));
      chk($sformatf("vec%0d_err", i), int'(cfg_err), int'(vecs[i].xe));
      if (vecs[i].xc >= 0)
        chk($sformatf("vec%0d_count", i), int'(match_count), vecs[i].xc);
    end

    // Randomized traffic against the reference model.
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       r_rst, r_ld, r_ovl, r_clr, r_vld, r_d;
      logic [7:0] r_pat;
      logic [3:0] r_len;
      r_rst = (c == 0) || ($urandom_range(0, 199) == 0);
      r_ld  = ($urandom_range(0, 15) == 0);
      r_pat = 8'($urandom);
      r_len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                          : 4'($urandom_range(1, 4));
      r_ovl = 1'($urandom);
      r_clr = ($urandom_range(0, 63) == 0);
      r_vld = ($urandom_range(0, 3) != 0);
      r_d   = 1'($urandom);
      @(negedge clk);
      drive(r_rst, r_ld, r_pat, r_len, r_ovl, r_clr, r_vld, r_d);
      #1;
      if (!r_rst || c > 0) begin
        chk("rnd_dout", int'(dout), int'(m_dout(r_rst, r_ld, r_vld, r_d)));
        if (c > 0) begin
          chk("rnd_err", int'(cfg_err), int'(m_err));
          chk("rnd_count", int'(match_count), m_cnt);
        end
      end
      m_step(r_rst, r_ld, r_pat, int'(r_len), r_ovl, r_clr, r_vld, r_d);
    end

    @(negedge clk);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
